// File: rtl/axi_lite_pkg.sv
// AXI4-lite shared constants: response codes,
// write-slave state encoding and strobe lane count.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_W  = 2'd1;
  localparam logic [1:0] ST_WAIT_AW = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam int STRB_W = 4;

endpackage

// File: rtl/axi_w_regfile.sv
// Byte-strobed register bank, async clear,
// exported flat with reg i at bits [i*32 +: 32].
module axi_w_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [31:0]              data,
  input  logic [STRB_W-1:0]        strb,
  output logic [NUM_REGS*32-1:0]   regs_flat
);

  logic [31:0] mem [NUM_REGS];

  // per-lane update of the addressed register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (strb[k]) begin
          mem[idx][8*k +: 8] <= data[8*k +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*32 +: 32] = mem[g];
  end

endmodule

// File: rtl/axi_lite_w_slave.sv
// AXI4-lite write slave: AW/W/B into a register bank.
// Define AXI_LITE_W_SLAVE_LOCK_EN to add the wr_lock input.
module axi_lite_w_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [3:0]                   wstrb,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [1:0]                   bresp,
`ifdef AXI_LITE_W_SLAVE_LOCK_EN
  input  logic                         wr_lock,
`endif
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]  wr_index
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SPAN =
    ADDR_W'(NUM_REGS * 4);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic              err;
  logic              locked;
  logic              wr_ok;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] eff_data;
  logic [STRB_W-1:0] eff_strb;
  logic [IDX_W-1:0]  idx;

  assign awready = (state == ST_IDLE)
                 | (state == ST_WAIT_AW);
  assign wready  = (state == ST_IDLE)
                 | (state == ST_WAIT_W);
  assign bvalid  = (state == ST_RESP);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign commit =
      ((state == ST_IDLE) & aw_hs & w_hs)
    | ((state == ST_WAIT_W) & w_hs)
    | ((state == ST_WAIT_AW) & aw_hs);

  // address from the captured copy once AW is done
  assign eff_addr = (state == ST_WAIT_W)
                  ? addr_q : awaddr;
  assign eff_data = (state == ST_WAIT_AW)
                  ? data_q : wdata;
  assign eff_strb = (state == ST_WAIT_AW)
                  ? strb_q : wstrb;

  assign offset = eff_addr - BASE_ADDR;
  assign err    = (eff_addr[1:0] != 2'b00)
                | (offset >= SPAN);
  assign idx    = offset[2 +: IDX_W];

`ifdef AXI_LITE_W_SLAVE_LOCK_EN
  assign locked = wr_lock;
`else
  assign locked = 1'b0;
`endif

  assign wr_ok = commit & ~err & ~locked;

  // next-state decode of the handshake FSM
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (aw_hs && w_hs) begin
          state_nxt = ST_RESP;
        end else if (aw_hs) begin
          state_nxt = ST_WAIT_W;
        end else if (w_hs) begin
          state_nxt = ST_WAIT_AW;
        end
      end
      (state == ST_WAIT_W): begin
        if (w_hs) state_nxt = ST_RESP;
      end
      (state == ST_WAIT_AW): begin
        if (aw_hs) state_nxt = ST_RESP;
      end
      (state == ST_RESP): begin
        if (bready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture the half that arrives first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (state == ST_IDLE) begin
      if (aw_hs && !w_hs) begin
        addr_q <= awaddr;
      end
      if (w_hs && !aw_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

  // response code and write strobe at commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp    <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      wr_pulse <= wr_ok;
      if (commit) begin
        bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (wr_ok) begin
        wr_index <= idx;
      end
    end
  end

  axi_w_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wr_ok),
    .idx       (idx),
    .data      (eff_data),
    .strb      (eff_strb),
    .regs_flat (regs_flat)
  );

endmodule

// File: tb/tb_axi_lite_w_slave.sv
// Directed bench for axi_lite_w_slave,
// default build, NUM_REGS = 16, BASE_ADDR = 0.
module tb_axi_lite_w_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         bvalid;
  logic         bready;
  logic [1:0]   bresp;
  logic [511:0] regs_flat;
  logic         wr_pulse;
  logic [3:0]   wr_index;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [16];

  axi_lite_w_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) begin
      f[i*32 +: 32] = m[i];
    end
    return f;
  endfunction

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    awaddr  = 32'hFFFF_FFFF;
    wdata   = 32'h0BAD_0BAD;
    wstrb   = 4'h0;
  endtask

  task automatic both(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
    @(negedge clk);
    awvalid = 1'b1;
    awaddr  = a;
    wvalid  = 1'b1;
    wdata   = d;
    wstrb   = s;
    chk("idle_awready", awready, 1'b1);
    chk("idle_wready", wready, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic resp(input string tag,
                      input logic [1:0] r,
                      input logic       p,
                      input logic [3:0] ix);
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, r);
    chk({tag, "_pulse"}, wr_pulse, p);
    if (p) chk({tag, "_index"}, wr_index, ix);
    chk({tag, "_regs"}, regs_flat, model_flat());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_bdrop"}, bvalid, 1'b0);
    chk({tag, "_pulse0"}, wr_pulse, 1'b0);
    chk({tag, "_awready"}, awready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = '0;
    rst_n  = 1'b0;
    bready = 1'b0;
    idle_inputs();
    #12;
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_pulse", wr_pulse, 1'b0);
    chk("rst_index", wr_index, 4'd0);
    chk("rst_regs", regs_flat, model_flat());
    @(negedge clk);
    rst_n = 1'b1;

    // 1: AW and W together
    both(32'h8, 32'hDEAD_BEEF, 4'hF);
    m[2] = 32'hDEAD_BEEF;
    resp("s1", 2'b00, 1'b1, 4'd2);

    // 2: preset reg1, then AW first
    both(32'h4, 32'hFFFF_FFFF, 4'hF);
    m[1] = 32'hFFFF_FFFF;
    resp("s2pre", 2'b00, 1'b1, 4'd1);
    @(negedge clk);
    awvalid = 1'b1;
    awaddr  = 32'h4;
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk("s2_awready0", awready, 1'b0);
      chk("s2_wready1", wready, 1'b1);
      chk("s2_nobvalid", bvalid, 1'b0);
      if (c < 2) @(negedge clk);
    end
    wvalid = 1'b1;
    wdata  = 32'h1234_5678;
    wstrb  = 4'b0101;
    @(negedge clk);
    idle_inputs();
    m[1] = 32'hFF34_FF78;
    resp("s2", 2'b00, 1'b1, 4'd1);

    // 3: W first, AW two cycles later
    @(negedge clk);
    wvalid = 1'b1;
    wdata  = 32'hA5A5_A5A5;
    wstrb  = 4'hF;
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      chk("s3_wready0", wready, 1'b0);
      chk("s3_awready1", awready, 1'b1);
      if (c < 1) @(negedge clk);
    end
    awvalid = 1'b1;
    awaddr  = 32'h0;
    @(negedge clk);
    idle_inputs();
    m[0] = 32'hA5A5_A5A5;
    resp("s3", 2'b00, 1'b1, 4'd0);

    // 4: out-of-range and misaligned
    both(32'h40, 32'h5555_5555, 4'hF);
    resp("s4_range", 2'b10, 1'b0, 4'd0);
    both(32'h6, 32'h6666_6666, 4'hF);
    resp("s4_misal", 2'b10, 1'b0, 4'd0);

    // zero strobe and top register
    both(32'hC, 32'h7777_7777, 4'h0);
    resp("zstrb", 2'b00, 1'b1, 4'd3);
    both(32'h3C, 32'hCAFE_F00D, 4'hF);
    m[15] = 32'hCAFE_F00D;
    resp("top", 2'b00, 1'b1, 4'd15);

    // 5: back-pressure on B
    both(32'hC, 32'h1111_1111, 4'hF);
    m[3] = 32'h1111_1111;
    awvalid = 1'b1;
    awaddr  = 32'h10;
    for (int c = 0; c < 5; c++) begin
      chk("s5_bvalid", bvalid, 1'b1);
      chk("s5_bresp", bresp, 2'b00);
      chk("s5_awready0", awready, 1'b0);
      @(negedge clk);
    end
    idle_inputs();
    chk("s5_regs", regs_flat, model_flat());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("s5_bdrop", bvalid, 1'b0);
    chk("s5_awready1", awready, 1'b1);

    // 6: reset while in WAIT_W
    @(negedge clk);
    awvalid = 1'b1;
    awaddr  = 32'h8;
    @(negedge clk);
    idle_inputs();
    chk("s6_waitw", awready, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) m[i] = '0;
    chk("s6_regs0", regs_flat, model_flat());
    chk("s6_bvalid", bvalid, 1'b0);
    chk("s6_awready", awready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_nobvalid", bvalid, 1'b0);
    both(32'h8, 32'hDEAD_BEEF, 4'hF);
    m[2] = 32'hDEAD_BEEF;
    resp("s6", 2'b00, 1'b1, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_w_slave.md
Name: axi_lite_w_slave

Overview:
AXI4-lite write-channel slave that consumes the AW/W/B traffic produced by the team's write master. It terminates the write address, write data and write response channels. It applies byte-strobed writes into a parameterised register bank and reports OKAY or SLVERR per transaction. Only one transaction is outstanding at a time. The register contents are exported flat to downstream control logic.

Parameters:
ADDR_W, 32, address width of awaddr
DATA_W, 32, data width; fixed at 32 (4 strobe lanes)
NUM_REGS, 16, number of 32-bit registers in the bank (power of two, 2..256)
BASE_ADDR, 32'h0000_0000, byte address of register 0

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_W  write byte address; sampled only at AW handshake
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data; sampled only at W handshake
wstrb  in  4  byte-lane enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
regs_flat  out  NUM_REGS*DATA_W  register bank; reg i at bits [i*32 +: 32]
wr_pulse  out  1  one-cycle pulse on a successful register write
wr_index  out  log2(NUM_REGS)  index written, valid with wr_pulse

Behaviour:
- Reset is asynchronous: clk, rst_n async active-low. While reset is asserted:
  - all registers = 0; state = IDLE
  - bvalid = 0, bresp = 2'b00, wr_pulse = 0, wr_index = 0
  - awready and wready are decoded from state, so both read 1 in IDLE
- States:
  - IDLE: awready = 1, wready = 1.
  - WAIT_W: address captured. awready = 0, wready = 1.
  - WAIT_AW: data and strobe captured. awready = 1, wready = 0.
  - RESP: bvalid = 1, awready = 0, wready = 0.
- Transitions:
  - IDLE: AW handshake only -> WAIT_W. W handshake only -> WAIT_AW. Both in the same cycle -> commit, then RESP.
  - WAIT_W: on W handshake -> commit, then RESP.
  - WAIT_AW: on AW handshake -> commit, then RESP.
  - RESP: on bvalid & bready -> IDLE. Otherwise hold; bvalid and bresp stay stable.
- Commit happens at the clock edge of the completing handshake:
  - offset = awaddr - BASE_ADDR.
  - Error if awaddr[1:0] != 0 OR offset >= NUM_REGS*4.
  - On error: bresp = SLVERR, no register changes, no wr_pulse.
  - Otherwise: bresp = OKAY. Register[offset[2 +: log2(NUM_REGS)]] lane k takes wdata[8k+7:8k] where wstrb[k] = 1; other lanes hold. wr_pulse = 1 for exactly one cycle, wr_index = that index.
  - wstrb = 0 on a valid address: OKAY with wr_pulse still asserted and no data change.
- Latency:
  - Register update is visible the cycle after the completing handshake; bvalid rises in that same cycle.
  - Minimum transaction: 2 cycles (AW+W cycle, then B cycle with bready = 1). The next AW/W is accepted the cycle after the B handshake.
- awaddr is not required to be held by the master after its handshake; the captured address is used. The same applies to wdata and wstrb.
- Reset mid-transaction: the captured address/data are discarded, no partial write, bvalid drops immediately, and state returns to IDLE.

Optional Feature:
AXI_LITE_W_SLAVE_LOCK_EN
- Enabled: adds input port wr_lock (1 bit). If wr_lock = 1 at the commit edge, the write is suppressed, bresp = SLVERR and no wr_pulse is generated. Address errors still report SLVERR.
- Disabled: the port is absent; only address errors produce SLVERR.

Decomposition:
- Package axi_lite_pkg holds:
  - response codes RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10 (EXOKAY/DECERR also defined, unused)
  - the write-slave state encoding IDLE/WAIT_W/WAIT_AW/RESP (2 bits)
  - the strobe-lane count constant (4)
- Sub-module axi_w_regfile: byte-strobed register bank with ports write enable, index, data and strobe, producing regs_flat. The FSM, address decode and B channel remain in the top module.

Test Plan:
1. Reset release, then AW 0x8 and W 0xDEADBEEF (wstrb 4'hF) in the same cycle -> reg2 = 0xDEADBEEF, bvalid with bresp 00 the next cycle, wr_pulse with wr_index = 2.
2. AW 0x4 first, W 0x12345678 three cycles later with wstrb 4'b0101 (reg1 preset 0xFFFFFFFF) -> reg1 = 0xFF34FF78, OKAY; awready stays 0 while in WAIT_W.
3. W first (0xA5A5A5A5, 4'hF), AW 0x0 two cycles later -> reg0 = 0xA5A5A5A5, OKAY; wready stays 0 while in WAIT_AW.
4. AW 0x40 with NUM_REGS = 16, then AW 0x6 misaligned -> both return SLVERR, all registers unchanged, no wr_pulse.
5. Hold bready = 0 for 5 cycles after a write -> bvalid and bresp stable, a new awvalid is not accepted; bready = 1 -> IDLE and awready = 1 the next cycle.
6. Assert rst_n = 0 while in WAIT_W -> registers cleared, bvalid = 0; the following complete write behaves like scenario 1.
